// File: rtl/calc_pkg.sv
// Shared key codes, ALU op encodings and sequencer state encoding for the
// calculator sequencer and the ALU it drives.
package calc_pkg;

  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_MUL = 4'd12;
  localparam logic [3:0] KEY_DIV = 4'd13;
  localparam logic [3:0] KEY_EQ  = 4'd14;
  localparam logic [3:0] KEY_CLR = 4'd15;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTER_A = 3'd1,
    ST_ENTER_B = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SHOW    = 3'd4,
    ST_ERROR   = 3'd5
  } state_t;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

  function automatic logic is_oper(input logic [3:0] k);
    return (k >= KEY_ADD) && (k <= KEY_DIV);
  endfunction

  // Operator keys are contiguous, so the op code is the offset from KEY_ADD.
  function automatic op_t key_to_op(input logic [3:0] k);
    logic [3:0] d;
    d = k - KEY_ADD;
    return op_t'(d[1:0]);
  endfunction

endpackage

// File: rtl/digit_accum.sv
// Decimal digit accumulator: value*10 + digit, with a flag saying whether the
// result still fits in W unsigned bits.
module digit_accum #(
  parameter int W = 16
) (
  input  logic [W-1:0] i_value,
  input  logic [3:0]   i_digit,
  output logic [W-1:0] o_result,
  output logic         o_fits
);

  logic [W+3:0] w_ext;
  logic [W+3:0] w_wide;

  // Four guard bits cover the worst case (2^W-1)*10+9 < 16*2^W.
  assign w_ext    = {4'd0, i_value};
  assign w_wide   = (w_ext << 3) + (w_ext << 1) + {{W{1'b0}}, i_digit};
  assign o_result = w_wide[W-1:0];
  assign o_fits   = (w_wide[W+3:W] == 4'd0);

endmodule

// File: rtl/calc_sequencer.sv
// Keypad calculator sequencer: collects two decimal operands and an operator,
// drives an external ALU, waits ALU_LAT cycles and captures the result.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int W       = 16,
  parameter int ALU_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [3:0]   key_code,
  output logic [W-1:0] alu_num1,
  output logic [W-1:0] alu_num2,
  output logic [1:0]   alu_op,
  input  logic [W-1:0] alu_res,
  input  logic         alu_isValid,
  output logic [W-1:0] display,
  output logic         busy,
  output logic         err,
  output logic         done,
  output state_t       dbg_state
);

  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(ALU_LAT - 1);

  state_t        r_state, w_state;
  logic [W-1:0]  r_a, w_a;
  logic [W-1:0]  r_b, w_b;
  op_t           r_op, w_op;
  logic [W-1:0]  r_res, w_res;
  logic [CW-1:0] r_cnt, w_cnt;
  logic          r_b_seen, w_b_seen;
  logic          r_done, w_done;

  logic [W-1:0]  w_acc_in, w_acc_out;
  logic          w_acc_fits;
  logic          w_is_digit, w_is_oper, w_is_eq, w_is_clr;

  // Fresh entry (IDLE/SHOW) starts from zero so the digit itself becomes A.
  assign w_acc_in = (r_state == ST_ENTER_B) ? r_b :
                    (r_state == ST_ENTER_A) ? r_a : '0;

  digit_accum #(.W(W)) u_digit_accum (
    .i_value  (w_acc_in),
    .i_digit  (key_code),
    .o_result (w_acc_out),
    .o_fits   (w_acc_fits)
  );

  assign w_is_digit = key_valid && is_digit(key_code);
  assign w_is_oper  = key_valid && is_oper(key_code);
  assign w_is_eq    = key_valid && (key_code == KEY_EQ);
  assign w_is_clr   = key_valid && (key_code == KEY_CLR);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= OP_ADD;
      r_res    <= '0;
      r_cnt    <= '0;
      r_b_seen <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_a      <= w_a;
      r_b      <= w_b;
      r_op     <= w_op;
      r_res    <= w_res;
      r_cnt    <= w_cnt;
      r_b_seen <= w_b_seen;
      r_done   <= w_done;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_a      = r_a;
    w_b      = r_b;
    w_op     = r_op;
    w_res    = r_res;
    w_cnt    = r_cnt;
    w_b_seen = r_b_seen;
    w_done   = 1'b0;

    if (w_is_clr) begin
      w_state  = ST_IDLE;
      w_a      = '0;
      w_b      = '0;
      w_op     = OP_ADD;
      w_res    = '0;
      w_cnt    = '0;
      w_b_seen = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_SHOW: begin
          if (w_is_digit) begin
            w_a      = w_acc_out;
            w_b      = '0;
            w_b_seen = 1'b0;
            w_state  = ST_ENTER_A;
          end else if (w_is_oper) begin
            // From SHOW the previous result becomes the left operand.
            w_a      = (r_state == ST_SHOW) ? r_res : '0;
            w_b      = '0;
            w_b_seen = 1'b0;
            w_op     = key_to_op(key_code);
            w_state  = ST_ENTER_B;
          end
        end
        ST_ENTER_A: begin
          if (w_is_digit) begin
            if (w_acc_fits) w_a = w_acc_out;
          end else if (w_is_oper) begin
            w_b      = '0;
            w_b_seen = 1'b0;
            w_op     = key_to_op(key_code);
            w_state  = ST_ENTER_B;
          end
        end
        ST_ENTER_B: begin
          if (w_is_digit) begin
            if (w_acc_fits) begin
              w_b      = w_acc_out;
              w_b_seen = 1'b1;
            end
          end else if (w_is_oper) begin
            if (!r_b_seen) w_op = key_to_op(key_code);
          end else if (w_is_eq && r_b_seen) begin
            w_cnt   = '0;
            w_state = ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (r_cnt == LAST_CNT) begin
            if (alu_isValid) begin
              w_res   = alu_res;
              w_done  = 1'b1;
              w_state = ST_SHOW;
            end else begin
              w_state = ST_ERROR;
            end
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end
        ST_ERROR: begin
          w_state = ST_ERROR;
        end
        default: begin
          w_state = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    display = '0;
    case (r_state)
      ST_ENTER_A: display = r_a;
      ST_ENTER_B: display = r_b_seen ? r_b : r_a;
      ST_EXEC:    display = r_b;
      ST_SHOW:    display = r_res;
      default:    display = '0;
    endcase
  end

  assign alu_num1  = r_a;
  assign alu_num2  = r_b;
  assign alu_op    = r_op;
  assign busy      = (r_state == ST_EXEC);
  assign err       = (r_state == ST_ERROR);
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: key-sequence vector table on an ALU_LAT=1 instance,
// plus hand-written latency, clear and reset sequences on an ALU_LAT=3 instance.
module tb_calc_sequencer;
  import calc_pkg::*;

  localparam int W = 16;
  localparam longint unsigned MAXV = (64'd1 << W) - 64'd1;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_valid;
  logic [3:0]   key_code;

  logic [W-1:0] a_num1, a_num2, a_res, a_disp;
  logic [1:0]   a_op;
  logic         a_valid, a_busy, a_err, a_done;
  state_t       a_state;

  logic [W-1:0] b_num1, b_num2, b_res, b_disp;
  logic [1:0]   b_op;
  logic         b_valid, b_busy, b_err, b_done;
  state_t       b_state;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0]   key;
    logic [W-1:0] disp;
    logic         busy;
    logic         err;
    logic [1:0]   op;
    logic         done;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  calc_sequencer #(.W(W), .ALU_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .alu_num1(a_num1), .alu_num2(a_num2), .alu_op(a_op),
    .alu_res(a_res), .alu_isValid(a_valid),
    .display(a_disp), .busy(a_busy), .err(a_err), .done(a_done),
    .dbg_state(a_state)
  );

  calc_sequencer #(.W(W), .ALU_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .alu_num1(b_num1), .alu_num2(b_num2), .alu_op(b_op),
    .alu_res(b_res), .alu_isValid(b_valid),
    .display(b_disp), .busy(b_busy), .err(b_err), .done(b_done),
    .dbg_state(b_state)
  );

  // Reference ALU: result invalid on overflow, negative difference or divide by zero.
  function automatic void alu_model(input logic [W-1:0] n1, input logic [W-1:0] n2,
                                    input logic [1:0] op,
                                    output logic [W-1:0] res, output logic ok);
    longint unsigned x, y, f;
    x  = longint'(n1);
    y  = longint'(n2);
    f  = 0;
    ok = 1'b1;
    case (op)
      2'd0: f = x + y;
      2'd1: begin ok = (x >= y); f = ok ? x - y : 0; end
      2'd2: f = x * y;
      default: begin ok = (y != 0); f = ok ? x / y : 0; end
    endcase
    if (f > MAXV) ok = 1'b0;
    res = f[W-1:0];
  endfunction

  always_comb alu_model(a_num1, a_num2, a_op, a_res, a_valid);
  always_comb alu_model(b_num1, b_num2, b_op, b_res, b_valid);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'd0;
  endtask

  function automatic void addv(input logic [3:0] k, input int d, input bit bz,
                               input bit e, input int o, input bit dn);
    vec_t v;
    v.key  = k;
    v.disp = W'(d);
    v.busy = bz;
    v.err  = e;
    v.op   = 2'(o);
    v.done = dn;
    vecs.push_back(v);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cycles;

    rst       = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'd0;

    //       key  disp   busy err op done
    addv( 1,     1, 0, 0, 0, 0);
    addv( 2,    12, 0, 0, 0, 0);
    addv(10,    12, 0, 0, 0, 0);
    addv( 3,     3, 0, 0, 0, 0);
    addv(14,    15, 1, 0, 0, 1);
    addv(15,     0, 0, 0, 0, 0);
    addv( 5,     5, 0, 0, 0, 0);
    addv(12,     5, 0, 0, 2, 0);
    addv( 4,     4, 0, 0, 2, 0);
    addv(14,    20, 1, 0, 2, 1);
    addv(11,    20, 0, 0, 1, 0);
    addv( 6,     6, 0, 0, 1, 0);
    addv(14,    14, 1, 0, 1, 1);
    addv( 7,     7, 0, 0, 1, 0);
    addv(10,     7, 0, 0, 0, 0);
    addv(11,     7, 0, 0, 1, 0);
    addv(14,     7, 0, 0, 1, 0);
    addv( 2,     2, 0, 0, 1, 0);
    addv(10,     2, 0, 0, 1, 0);
    addv(14,     5, 1, 0, 1, 1);
    addv(15,     0, 0, 0, 0, 0);
    addv( 6,     6, 0, 0, 0, 0);
    addv( 5,    65, 0, 0, 0, 0);
    addv( 5,   655, 0, 0, 0, 0);
    addv( 3,  6553, 0, 0, 0, 0);
    addv( 5, 65535, 0, 0, 0, 0);
    addv( 9, 65535, 0, 0, 0, 0);
    addv(14, 65535, 0, 0, 0, 0);
    addv(10, 65535, 0, 0, 0, 0);
    addv( 1,     1, 0, 0, 0, 0);
    addv(14,     0, 1, 1, 0, 0);
    addv( 3,     0, 0, 1, 0, 0);
    addv(10,     0, 0, 1, 0, 0);
    addv(15,     0, 0, 0, 0, 0);
    addv( 8,     8, 0, 0, 0, 0);
    addv(13,     8, 0, 0, 3, 0);
    addv( 0,     0, 0, 0, 3, 0);
    addv(14,     0, 1, 1, 3, 0);
    addv(15,     0, 0, 0, 0, 0);
    addv(14,     0, 0, 0, 0, 0);
    addv(10,     0, 0, 0, 0, 0);
    addv( 9,     9, 0, 0, 0, 0);
    addv(14,     9, 1, 0, 0, 1);

    repeat (2) @(negedge clk);
    chk("rst_disp",  32'(a_disp),  32'd0);
    chk("rst_busy",  32'(a_busy),  32'd0);
    chk("rst_err",   32'(a_err),   32'd0);
    chk("rst_done",  32'(a_done),  32'd0);
    chk("rst_num1",  32'(a_num1),  32'd0);
    chk("rst_num2",  32'(a_num2),  32'd0);
    chk("rst_op",    32'(a_op),    32'd0);
    chk("rst_state", 32'(a_state), 32'(ST_IDLE));
    rst = 1'b0;

    foreach (vecs[i]) begin
      press(vecs[i].key);
      chk($sformatf("v%0d_busy", i), 32'(a_busy), 32'(vecs[i].busy));
      if (vecs[i].busy) @(negedge clk);
      chk($sformatf("v%0d_disp", i), 32'(a_disp), 32'(vecs[i].disp));
      chk($sformatf("v%0d_err",  i), 32'(a_err),  32'(vecs[i].err));
      chk($sformatf("v%0d_op",   i), 32'(a_op),   32'(vecs[i].op));
      chk($sformatf("v%0d_done", i), 32'(a_done), 32'(vecs[i].done));
    end

    // done is a single-cycle pulse and the operands stay on the ALU ports.
    press(15); press(2); press(12); press(3); press(14);
    chk("pulse_busy", 32'(a_busy), 32'd1);
    @(negedge clk);
    chk("pulse_done1", 32'(a_done), 32'd1);
    chk("pulse_disp1", 32'(a_disp), 32'd6);
    chk("pulse_num1",  32'(a_num1), 32'd2);
    chk("pulse_num2",  32'(a_num2), 32'd3);
    @(negedge clk);
    chk("pulse_done0", 32'(a_done), 32'd0);
    chk("pulse_disp2", 32'(a_disp), 32'd6);
    chk("pulse_busy0", 32'(a_busy), 32'd0);

    // ALU_LAT=3: EXEC lasts exactly three cycles.
    press(15); press(4); press(10); press(5); press(14);
    busy_cycles = 0;
    while (b_busy && busy_cycles < 10) begin
      busy_cycles++;
      @(negedge clk);
    end
    chk("lat3_busy_cycles", 32'(busy_cycles), 32'd3);
    chk("lat3_done", 32'(b_done), 32'd1);
    chk("lat3_disp", 32'(b_disp), 32'd9);

    // Clear during EXEC aborts the operation.
    press(15); press(1); press(10); press(2); press(14);
    chk("clr_exec_busy_before", 32'(b_busy), 32'd1);
    press(15);
    chk("clr_exec_state", 32'(b_state), 32'(ST_IDLE));
    chk("clr_exec_busy",  32'(b_busy),  32'd0);
    chk("clr_exec_done",  32'(b_done),  32'd0);
    chk("clr_exec_disp",  32'(b_disp),  32'd0);
    chk("clr_exec_num1",  32'(b_num1),  32'd0);
    @(negedge clk);
    chk("clr_exec_done_later", 32'(b_done), 32'd0);
    chk("clr_exec_disp_later", 32'(b_disp), 32'd0);

    // Reset in the second EXEC cycle, with a key arriving in the same cycle.
    press(15); press(1); press(10); press(2); press(14);
    chk("rstx_busy_before", 32'(b_busy), 32'd1);
    @(negedge clk);
    rst       = 1'b1;
    key_valid = 1'b1;
    key_code  = 4'd3;
    @(negedge clk);
    rst       = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'd0;
    chk("rstx_state", 32'(b_state), 32'(ST_IDLE));
    chk("rstx_busy",  32'(b_busy),  32'd0);
    chk("rstx_err",   32'(b_err),   32'd0);
    chk("rstx_done",  32'(b_done),  32'd0);
    chk("rstx_disp",  32'(b_disp),  32'd0);
    chk("rstx_num1",  32'(b_num1),  32'd0);
    chk("rstx_num2",  32'(b_num2),  32'd0);
    chk("rstx_op",    32'(b_op),    32'd0);
    @(negedge clk);
    chk("rstx_done_later",  32'(b_done),  32'd0);
    chk("rstx_state_later", 32'(b_state), 32'(ST_IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 SHALL have parameter W, default 16, meaning operand/result width in bits.
REQ-002 SHALL have parameter ALU_LAT, default 1, meaning cycles from ALU input change to valid res/isValid.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port key_valid, input, 1, one-cycle strobe qualifying key_code.
REQ-006 SHALL have port key_code, input, 4, with 0-9 as digit, 10 as add, 11 as sub, 12 as mul, 13 as div, 14 as equals, and 15 as clear.
REQ-007 SHALL have port alu_num1, output, W, left operand to ALU.
REQ-008 SHALL have port alu_num2, output, W, right operand to ALU.
REQ-009 SHALL have port alu_op, output, 2, with 0 as sum, 1 as sub, 2 as mul, and 3 as div.
REQ-010 SHALL have port alu_res, input, W, ALU result.
REQ-011 SHALL have port alu_isValid, input, 1, ALU result legal (0 = overflow/div-by-zero).
REQ-012 SHALL have port display, output, W, value to show.
REQ-013 SHALL have port busy, output, 1, high while in EXEC.
REQ-014 SHALL have port err, output, 1, high while in ERROR.
REQ-015 SHALL have port done, output, 1, one-cycle pulse when a result is captured.

Function
REQ-016 SHALL implement the state machine IDLE, ENTER_A, ENTER_B, EXEC, SHOW, ERROR.
REQ-017 SHALL accept keys only on key_valid=1; keys SHALL be dropped while in EXEC.
REQ-018 SHALL process a clear key (15) in any state, including EXEC, by going to IDLE and zeroing A, B, op and display next cycle.
REQ-019 SHALL, on a digit d, update the operand as value*10+d, using W-bit unsigned binary.
REQ-020 SHALL ignore the digit, leaving the operand unchanged, when value*10+d exceeds 2^W-1.
REQ-021 SHALL, in IDLE or SHOW, have a digit load A=d, clear B, and go to ENTER_A.
REQ-022 SHALL, in ENTER_A, have an operator key latch op and go to ENTER_B with B=0 and no B digit entered.
REQ-023 SHALL, in IDLE, have an operator key use A=0 and follow REQ-022.
REQ-024 SHALL, in SHOW, have an operator key copy the last result into A, then follow REQ-022 (chaining).
REQ-025 SHALL, in ENTER_B before any B digit, have an operator key replace op; after a B digit, operator keys SHALL be ignored.
REQ-026 SHALL, in ENTER_B with at least one B digit, have the equals key go to EXEC; otherwise equals SHALL be ignored.
REQ-027 SHALL ignore the equals key in IDLE, ENTER_A, SHOW and ERROR.
REQ-028 SHALL keep alu_num1=A, alu_num2=B and alu_op=op at all times.
REQ-029 SHALL hold EXEC for exactly ALU_LAT cycles; on the last cycle it SHALL sample alu_res/alu_isValid.
REQ-030 SHALL, when alu_isValid=1, store the result, pulse done for 1 cycle and go to SHOW.
REQ-031 SHALL, when alu_isValid=0, go to ERROR with no done pulse.
REQ-032 SHALL drive display as follows: A in ENTER_A, B in ENTER_B after a B digit (else A), the result in SHOW, and 0 in IDLE and ERROR.
REQ-033 SHALL leave ERROR only via the clear key; all other keys SHALL be ignored in ERROR.

Reset
REQ-034 SHALL, on rst=1 at a clock edge, make the state IDLE, clear A, B, op, the result and the counter, and make display=0, busy=0, err=0 and done=0.
REQ-035 SHALL give rst priority over any key arriving in the same cycle, including a mid-EXEC arrival.

Structure
REQ-036 SHALL place the key-code constants, op encodings and state encoding in a shared package calc_pkg, which the ALU also uses.
REQ-037 SHALL put the digit accumulator (multiply-by-10-add with overflow reject) in a sub-module digit_accum.

Verification
REQ-038 SHALL cover chained entry: keys 1,2,+,3,= -> busy for 1 cycle, done pulse, display=15, alu_op=0.
REQ-039 SHALL cover digit overflow: keys 6,5,5,3,5,9 -> display=65535 after 5th digit, 9 ignored, display still 65535.
REQ-040 SHALL cover divide by zero: keys 8,div,0,= with alu_isValid=0 -> err=1, display=0, no done; clear -> IDLE, err=0.
REQ-041 SHALL cover chaining: 5,*,4,= then -,6,= -> displays 20 then 14.
REQ-042 SHALL cover operator replace: 7,+,-,2,= -> alu_op=1, display=5; equals before B digit is ignored.
REQ-043 SHALL cover reset mid-EXEC with ALU_LAT=3: rst in 2nd EXEC cycle -> next cycle IDLE, all outputs 0, no done.
